// File: rtl/spawn_scheduler.sv
// Cluster spawn scheduler: turns per-core TRIGGER_SPAWN toggles and BOOT requests
// into queued start addresses, dispatched to the lowest-index idle core.
module spawn_scheduler #(
  parameter int N_CORES     = 4,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                   proc_clock,
  input  logic                   reset,
  input  logic                   BOOT_VALID,
  input  logic [7:0]             BOOT_ADDR,
  input  logic [N_CORES-1:0]     TRIGGER_SPAWN,
  input  logic [8*N_CORES-1:0]   SPAWN_ADDR,
  input  logic [N_CORES-1:0]     RUN,
  output logic [N_CORES-1:0]     START,
  output logic [8*N_CORES-1:0]   START_ADDR,
  output logic [4:0]             QUEUE_COUNT,
  output logic [7:0]             DROP_COUNT,
  output logic                   ALL_IDLE
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [N_CORES-1:0]   last_trig_q;
  logic [N_CORES-1:0]   pend_q, pend_d;
  logic [8*N_CORES-1:0] pend_addr_q, pend_addr_d;
  logic [N_CORES-1:0]   reserved_q, reserved_d;
  logic [N_CORES-1:0]   start_q, start_d;
  logic [8*N_CORES-1:0] start_addr_q, start_addr_d;
  logic [7:0]           fifo_q [QUEUE_DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [4:0]           count_q, count_d;
  logic [CW-1:0]        rr_q, rr_d;
  logic [7:0]           drop_q, drop_d;
  logic                 all_idle_q, all_idle_d;

  logic [N_CORES-1:0]   req, idle;
  logic                 deq, enq, can_write, found;
  logic [7:0]           wdata;
  logic [CW-1:0]        disp_idx, idx_c;
  logic [3:0]           n_drops;
  logic [8:0]           drop_sum;

  always_comb begin
    req       = TRIGGER_SPAWN ^ last_trig_q;
    idle      = ~RUN & ~reserved_q & ~start_q;
    deq       = (count_q != 5'd0) && (|idle);
    can_write = (count_q < 5'(QUEUE_DEPTH)) || deq;

    disp_idx = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (idle[i]) disp_idx = CW'(i);
    end

    enq         = 1'b0;
    wdata       = BOOT_ADDR;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    rr_d        = rr_q;
    n_drops     = 4'd0;
    found       = 1'b0;
    idx_c       = '0;

    // Boot wins the single write port; otherwise round-robin after the last grant.
    if (BOOT_VALID) begin
      if (can_write) enq = 1'b1;
      else           n_drops = n_drops + 4'd1;
    end else begin
      for (int k = 1; k <= N_CORES; k++) begin
        idx_c = CW'((int'(rr_q) + k) % N_CORES);
        if (!found && pend_q[idx_c]) begin
          found = 1'b1;
          if (can_write) begin
            enq           = 1'b1;
            wdata         = pend_addr_q[{idx_c, 3'b000} +: 8];
            pend_d[idx_c] = 1'b0;
            rr_d          = idx_c;
          end
        end
      end
    end

    for (int i = 0; i < N_CORES; i++) begin
      if (req[i]) begin
        if (pend_q[i]) begin
          n_drops = n_drops + 4'd1;
        end else begin
          pend_d[i]            = 1'b1;
          pend_addr_d[8*i +: 8] = SPAWN_ADDR[8*i +: 8];
        end
      end
    end

    drop_sum = {1'b0, drop_q} + {5'b0, n_drops};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    count_d  = count_q + {4'b0, enq} - {4'b0, deq};
    wr_ptr_d = wr_ptr_q + PW'(enq);
    rd_ptr_d = rd_ptr_q + PW'(deq);

    // A reservation holds a core from dispatch until its RUN is seen after START.
    start_d      = '0;
    start_addr_d = start_addr_q;
    reserved_d   = reserved_q & ~(RUN & ~start_q);
    if (deq) begin
      start_d[disp_idx]                     = 1'b1;
      start_addr_d[{disp_idx, 3'b000} +: 8] = fifo_q[rd_ptr_q];
      reserved_d[disp_idx]                  = 1'b1;
    end

    all_idle_d = (count_q == 5'd0) && (pend_q == '0) && (&idle);
  end

  always_ff @(posedge proc_clock) begin
    last_trig_q <= TRIGGER_SPAWN;
    if (reset) begin
      pend_q       <= '0;
      pend_addr_q  <= '0;
      reserved_q   <= '0;
      start_q      <= '0;
      start_addr_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= 5'd0;
      rr_q         <= '0;
      drop_q       <= 8'd0;
      all_idle_q   <= 1'b1;
    end else begin
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      reserved_q   <= reserved_d;
      start_q      <= start_d;
      start_addr_q <= start_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      rr_q         <= rr_d;
      drop_q       <= drop_d;
      all_idle_q   <= all_idle_d;
    end
  end

  always_ff @(posedge proc_clock) begin
    if (!reset && enq) fifo_q[wr_ptr_q] <= wdata;
  end

  assign START       = start_q;
  assign START_ADDR  = start_addr_q;
  assign QUEUE_COUNT = count_q;
  assign DROP_COUNT  = drop_q;
  assign ALL_IDLE    = all_idle_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Testbench for spawn_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_spawn_scheduler;

  localparam int NC = 4;
  localparam int QD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          bootValid;
  logic [7:0]    bootAddr;
  logic [NC-1:0] trig;
  logic [8*NC-1:0] spawnAddr;
  logic [NC-1:0] run;
  logic [NC-1:0] start;
  logic [8*NC-1:0] startAddr;
  logic [4:0]    qCount;
  logic [7:0]    dropCount;
  logic          allIdle;

  always #5 clk = ~clk;

  spawn_scheduler #(.N_CORES(NC), .QUEUE_DEPTH(QD)) dut (
    .proc_clock   (clk),
    .reset        (reset),
    .BOOT_VALID   (bootValid),
    .BOOT_ADDR    (bootAddr),
    .TRIGGER_SPAWN(trig),
    .SPAWN_ADDR   (spawnAddr),
    .RUN          (run),
    .START        (start),
    .START_ADDR   (startAddr),
    .QUEUE_COUNT  (qCount),
    .DROP_COUNT   (dropCount),
    .ALL_IDLE     (allIdle)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pending queue, per-core latches and reservations
  int            mq[$];
  bit            mPend[NC];
  logic [7:0]    mPaddr[NC];
  int            mLast;
  bit            mResv[NC];
  logic [NC-1:0] mStart;
  logic [7:0]    mSaddr[NC];
  int            mDrops;
  logic [NC-1:0] mLastTrig;
  bit            mAllIdle;

  int phase[NC];
  int cnt[NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    bit idleV[NC];
    bit oldPend[NC];
    int core, nd, head, g;
    bit deq, canWrite, allIdleNext;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < NC; i++) begin
        mPend[i] = 0; mPaddr[i] = 8'h00; mResv[i] = 0; mSaddr[i] = 8'h00;
      end
      mLast = 0; mDrops = 0; mStart = '0; mLastTrig = trig; mAllIdle = 1;
      return;
    end
    core = -1;
    allIdleNext = (mq.size() == 0);
    for (int i = 0; i < NC; i++) begin
      idleV[i] = !run[i] && !mResv[i] && !mStart[i];
      if (!idleV[i] || mPend[i]) allIdleNext = 0;
      if (idleV[i] && core < 0) core = i;
    end
    deq = (mq.size() > 0) && (core >= 0);
    canWrite = (mq.size() < QD) || deq;
    for (int i = 0; i < NC; i++)
      if (mResv[i] && run[i] && !mStart[i]) mResv[i] = 0;
    mStart = '0;
    if (deq) begin
      head = mq.pop_front();
      mStart[core] = 1'b1;
      mSaddr[core] = head[7:0];
      mResv[core] = 1;
    end
    nd = 0;
    oldPend = mPend;
    if (bootValid) begin
      if (canWrite) mq.push_back(int'(bootAddr));
      else nd++;
    end else begin
      for (int k = 1; k <= NC; k++) begin
        g = (mLast + k) % NC;
        if (oldPend[g]) begin
          if (canWrite) begin
            mq.push_back(int'(mPaddr[g]));
            mPend[g] = 0;
            mLast = g;
          end
          break;
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (trig[i] !== mLastTrig[i]) begin
        if (oldPend[i]) nd++;
        else begin
          mPend[i] = 1;
          mPaddr[i] = spawnAddr[8*i +: 8];
        end
      end
    end
    mLastTrig = trig;
    mDrops = (mDrops + nd > 255) ? 255 : mDrops + nd;
    mAllIdle = allIdleNext;
  endtask

  task automatic checkOutput();
    logic [31:0] expAddr;
    for (int i = 0; i < NC; i++) expAddr[8*i +: 8] = mSaddr[i];
    chk("START", {28'b0, start}, {28'b0, mStart});
    chk("START_ADDR", startAddr, expAddr);
    chk("QUEUE_COUNT", {27'b0, qCount}, 32'(mq.size()));
    chk("DROP_COUNT", {24'b0, dropCount}, 32'(mDrops));
    chk("ALL_IDLE", {31'b0, allIdle}, {31'b0, mAllIdle});
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; bootValid = 1'b0; bootAddr = 8'h00;
    trig = '0; spawnAddr = '0; run = '0;
    @(negedge clk);
    applyStimulus();
    applyStimulus();
    chk("reset_qcount", {27'b0, qCount}, 32'd0);
    chk("reset_allidle", {31'b0, allIdle}, 32'd1);
    reset = 1'b0;

    $display("[TB] boot");
    bootValid = 1'b1; bootAddr = 8'h10;
    applyStimulus();
    bootValid = 1'b0;
    applyStimulus();
    chk("boot_start", {28'b0, start}, 32'h1);
    chk("boot_addr", {24'b0, startAddr[7:0]}, 32'h10);
    applyStimulus();
    chk("boot_pulse_end", {28'b0, start}, 32'h0);
    chk("boot_allidle", {31'b0, allIdle}, 32'd0);
    run = 4'b0001;
    applyStimulus();

    $display("[TB] chained spawn");
    trig[0] = 1'b1; spawnAddr[7:0] = 8'h20;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    chk("chain_start", {28'b0, start}, 32'h2);
    chk("chain_addr", {24'b0, startAddr[15:8]}, 32'h20);
    run = 4'b0011;
    applyStimulus();

    $display("[TB] simultaneous requests");
    run = 4'b1111;
    trig = trig ^ 4'b1111;
    spawnAddr = 32'h33323130;
    applyStimulus();
    for (int i = 0; i < 4; i++) applyStimulus();
    chk("simul_qcount", {27'b0, qCount}, 32'd4);
    run = 4'b1011;
    applyStimulus();
    chk("release2_start", {28'b0, start}, 32'h4);
    chk("release2_addr", {24'b0, startAddr[23:16]}, 32'h31);
    run = 4'b0111;
    applyStimulus();
    chk("release3_start", {28'b0, start}, 32'h8);
    chk("release3_addr", {24'b0, startAddr[31:24]}, 32'h32);
    run = 4'b1111;
    applyStimulus();

    $display("[TB] full queue");
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bootValid = 1'b1; bootAddr = 8'(8'h40 + k);
      applyStimulus();
    end
    bootValid = 1'b0;
    applyStimulus();
    chk("full_qcount", {27'b0, qCount}, 32'd8);
    chk("full_drop", {24'b0, dropCount}, 32'd1);
    trig[1] = ~trig[1]; spawnAddr[15:8] = 8'hA1;
    applyStimulus();
    trig[1] = ~trig[1]; spawnAddr[15:8] = 8'hA2;
    applyStimulus();
    chk("repeat_toggle_drop", {24'b0, dropCount}, 32'd2);
    bootValid = 1'b1;
    for (int k = 0; k < 260; k++) applyStimulus();
    bootValid = 1'b0;
    chk("drop_saturate", {24'b0, dropCount}, 32'd255);

    $display("[TB] reservation");
    run = 4'b1011;
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    bootValid = 1'b1; bootAddr = 8'h50;
    applyStimulus();
    bootValid = 1'b0;
    applyStimulus();
    chk("resv_first_start", {28'b0, start}, 32'h4);
    bootValid = 1'b1; bootAddr = 8'h51;
    applyStimulus();
    bootValid = 1'b0;
    applyStimulus();
    applyStimulus();
    chk("resv_no_restart", {28'b0, start}, 32'h0);
    chk("resv_qcount", {27'b0, qCount}, 32'd1);
    run = 4'b1111;
    applyStimulus();
    applyStimulus();
    chk("resv_running", {28'b0, start}, 32'h0);
    run = 4'b1011;
    applyStimulus();
    chk("resv_reselect", {28'b0, start}, 32'h4);
    chk("resv_reselect_addr", {24'b0, startAddr[23:16]}, 32'h51);

    $display("[TB] reset mid-operation");
    run = 4'b1111; trig = 4'b1000;
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bootValid = 1'b1; bootAddr = 8'(8'h60 + k);
      applyStimulus();
    end
    bootValid = 1'b0;
    trig = 4'b1010; spawnAddr[15:8] = 8'h77;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    chk("midreset_qcount", {27'b0, qCount}, 32'd0);
    chk("midreset_start", {28'b0, start}, 32'h0);
    for (int k = 0; k < 3; k++) applyStimulus();
    chk("midreset_no_req", {27'b0, qCount}, 32'd0);
    run = 4'b0000;
    applyStimulus();
    applyStimulus();
    chk("midreset_allidle", {31'b0, allIdle}, 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < NC; i++) begin phase[i] = 0; cnt[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NC; i++) begin
        if (phase[i] == 0 && mStart[i]) begin
          phase[i] = 1; cnt[i] = $urandom_range(0, 2);
        end else if (phase[i] == 1) begin
          if (cnt[i] == 0) begin run[i] = 1'b1; phase[i] = 2; cnt[i] = $urandom_range(1, 8); end
          else cnt[i]--;
        end else if (phase[i] == 2) begin
          if (cnt[i] == 0) begin run[i] = 1'b0; phase[i] = 0; end
          else cnt[i]--;
        end
        if ($urandom_range(0, 7) == 0) trig[i] = ~trig[i];
      end
      spawnAddr = $urandom;
      bootValid = ($urandom_range(0, 3) == 0);
      bootAddr  = 8'($urandom);
      reset     = ($urandom_range(0, 499) == 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
